// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the debounced sequence detector.
// Build option: SEQDET_NONOVERLAP_EN selects non-overlapping matching.
package seqdet_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HIT  = 2'b10,
    DONE = 2'b11
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debouncer_n.sv
// Button debouncer: 2-flop synchroniser, stability counter, rise pulse.
// The debounced level only moves after DEB_CYCLES consistent samples.
module debouncer_n #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] C_MAX = DW'(DEB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic [DW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_s1   <= raw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      if (r_s2 != r_level) begin
        if (r_cnt == C_MAX) begin
          r_level <= r_s2;
          r_cnt   <= '0;
          r_rise  <= r_s2;
        end else begin
          r_cnt <= r_cnt + DW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/debounced_seq_detector.sv
// Debounced capture of a word, scanned MSB-first for PATTERN (Moore FSM).
// Define SEQDET_NONOVERLAP_EN to restart matching after every hit.
module debounced_seq_detector
  import seqdet_pkg::*;
#(
  parameter int                 WIDTH      = 8,
  parameter int                 PAT_LEN    = 3,
  parameter logic [PAT_LEN-1:0] PATTERN    = 3'b101,
  parameter int                 DEB_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read,
  input  logic [WIDTH-1:0]         in,
  output logic                     out,
  output logic [cnt_w(WIDTH)-1:0]  hit_count,
  output logic                     busy,
  output logic                     done,
  output logic [ST_W-1:0]          state
);

  localparam int CW = cnt_w(WIDTH);
  localparam int SW = cnt_w(PAT_LEN);
  localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);
  localparam logic [SW-1:0] C_PL    = SW'(PAT_LEN);
`ifdef SEQDET_NONOVERLAP_EN
  localparam bit NONOVL = 1'b1;
`else
  localparam bit NONOVL = 1'b0;
`endif

  logic w_level;
  logic w_step;

  debouncer_n #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk  (clk),
    .reset(reset),
    .raw  (read),
    .level(w_level),
    .rise (w_step)
  );

  state_t             r_state;
  logic [WIDTH-1:0]   r_word;
  logic [CW-1:0]      r_rem;
  logic [PAT_LEN-1:0] r_hist;
  logic [SW-1:0]      r_seen;
  logic [CW-1:0]      r_hits;
  logic               r_out;
  logic               r_busy;
  logic               r_done;

  logic               w_b;
  logic [PAT_LEN:0]   w_sh;
  logic [PAT_LEN-1:0] w_hist_nxt;
  logic [SW-1:0]      w_seen_nxt;
  logic               w_hit;

  // Widen before truncating so PAT_LEN==1 needs no special case.
  assign w_b        = r_word[WIDTH-1];
  assign w_sh       = {r_hist, w_b};
  assign w_hist_nxt = w_sh[PAT_LEN-1:0];
  assign w_seen_nxt = (r_seen == C_PL) ? r_seen : r_seen + SW'(1);
  assign w_hit      = (w_hist_nxt == PATTERN) && (w_seen_nxt == C_PL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_rem   <= '0;
      r_hist  <= '0;
      r_seen  <= '0;
      r_hits  <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_step) begin
            r_word  <= in;
            r_rem   <= C_WIDTH;
            r_hist  <= '0;
            r_seen  <= '0;
            r_hits  <= '0;
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN, HIT: begin
          if (r_rem != '0) begin
            r_word <= r_word << 1;
            r_rem  <= r_rem - CW'(1);
            r_hist <= (w_hit && NONOVL) ? '0 : w_hist_nxt;
            r_seen <= (w_hit && NONOVL) ? '0 : w_seen_nxt;
            if (w_hit) begin
              r_state <= HIT;
              r_out   <= 1'b1;
              r_hits  <= r_hits + CW'(1);
            end else begin
              r_state <= RUN;
              r_out   <= 1'b0;
            end
          end else begin
            r_state <= DONE;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          // A held button keeps the level high, so no retrigger here.
          if (!w_level) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_out   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign out       = r_out;
  assign hit_count = r_hits;
  assign busy      = r_busy;
  assign done      = r_done;
  assign state     = r_state;

endmodule
